// File: rtl/ctrl_gen.sv
// Multi-cycle SISC controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with branch evaluation,
// MEM wait handshake with timeout, and a registered HALT. Optional perf counters: CTRL_PERF_EN.
module ctrl_gen #(
  parameter int OPC_W    = 4,
  parameter int STAT_W   = 4,
  parameter int ALU_OP_W = 4,
  parameter int MAX_WAIT = 15,
  parameter int WCNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [STAT_W-1:0]   mm,
  input  logic [STAT_W-1:0]   stat,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_sel,
  output logic                br_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                mem_req,
  output logic                dm_we,
  output logic                halted,
  output logic                err
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]         cyc_cnt,
  output logic [31:0]         ret_cnt
`endif
);

  localparam logic [OPC_W-1:0] OP_REG_OP = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_REG_IM = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_BRA    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BRR    = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BNE    = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_BNR    = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_LOD    = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_STR    = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_HLT    = OPC_W'(15);

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_IMM  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_ADDR = ALU_OP_W'(3);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_halted;
  logic                r_err;
  logic                w_cond;
  logic                w_is_mem;
  logic                w_timeout;
  logic                w_timeout_evt;

  assign w_cond    = |(mm & stat);
  assign w_is_mem  = (opcode == OP_LOD) || (opcode == OP_STR);
  assign w_timeout = (r_wcnt == WCNT_W'(MAX_WAIT));

  always_comb begin
    w_state_next  = r_state;
    w_timeout_evt = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    br_sel        = 1'b0;
    alu_op        = '0;
    rf_we         = 1'b0;
    wb_sel        = 1'b0;
    mem_req       = 1'b0;
    dm_we         = 1'b0;
    case (r_state)
      S_START: w_state_next = S_FETCH;
      S_FETCH: begin
        ir_load      = 1'b1;
        pc_write     = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_state_next = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
        // Positive-sense branches take on a CC hit, negative-sense on a miss
        if (((opcode == OP_BRA || opcode == OP_BRR) && w_cond) ||
            ((opcode == OP_BNE || opcode == OP_BNR) && !w_cond)) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (opcode == OP_BRR) || (opcode == OP_BNR);
        end
      end
      S_EXECUTE: begin
        w_state_next = S_MEM;
        if (opcode == OP_REG_OP)
          alu_op = ALU_ADD;
        else if (opcode == OP_REG_IM || w_is_mem)
          alu_op = ALU_ADDR;
      end
      S_MEM: begin
        if (w_is_mem) begin
          mem_req = 1'b1;
          alu_op  = ALU_ADDR;
          dm_we   = (opcode == OP_STR);
          // Completion beats timeout when both land on the same cycle
          if (mem_ready) begin
            w_state_next = S_WRITEBACK;
          end else if (w_timeout) begin
            w_state_next  = S_HALT;
            w_timeout_evt = 1'b1;
          end
        end else begin
          if (opcode == OP_REG_IM)
            alu_op = ALU_IMM;
          w_state_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        rf_we        = (opcode == OP_REG_OP) || (opcode == OP_REG_IM) || (opcode == OP_LOD);
        wb_sel       = (opcode == OP_LOD);
        w_state_next = S_FETCH;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_START;
      r_wcnt   <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_MEM && w_state_next == S_MEM)
        r_wcnt <= r_wcnt + 1'b1;
      else
        r_wcnt <= '0;
      if (w_state_next == S_HALT)
        r_halted <= 1'b1;
      if (w_timeout_evt)
        r_err <= 1'b1;
    end
  end

  assign halted = r_halted;
  assign err    = r_err;

`ifdef CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_ret_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (r_state != S_START && r_state != S_HALT)
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if ((r_state == S_WRITEBACK && w_state_next == S_FETCH) ||
          (r_state == S_DECODE && w_state_next == S_HALT))
        r_ret_cnt <= r_ret_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`endif

endmodule

// File: tb/tb_ctrl_gen.sv
// Self-checking bench for ctrl_gen: directed vector table, hand-written MEM timeout / HALT
// sequences, and random instruction streams against an instruction-level expectation model.
module tb_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode, mm, stat;
  logic       mem_ready;
  logic       ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, mem_req, dm_we, halted, err;
  logic [3:0] alu_op;
`ifdef CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  ctrl_gen dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
    .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .mem_req(mem_req), .dm_we(dm_we),
    .halted(halted), .err(err)
`ifdef CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [3:0]  stat;
    logic        rdy;
    logic [13:0] exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];
  vec_t q[$];
  logic [3:0] ops [14] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11,
                           4'd3, 4'd8, 4'd9, 4'd12, 4'd13};

  function automatic logic [13:0] mk(logic il, logic pw, logic ps, logic bs, logic [3:0] alu,
                                     logic rf, logic wb, logic mr, logic dw, logic h, logic e);
    return {il, pw, ps, bs, alu, rf, wb, mr, dw, h, e};
  endfunction

  function automatic logic [13:0] dut_out();
    return {ir_load, pc_write, pc_sel, br_sel, alu_op, rf_we, wb_sel, mem_req, dm_we, halted, err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s, input logic r);
    opcode = op; mm = m; stat = s; mem_ready = r;
    #1;
  endtask

  task automatic step(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s, input logic r,
                      input logic [13:0] exp, input string nm);
    drive(op, m, s, r);
    $display("[TB] %s op=%0d mm=%h stat=%h rdy=%0b out=%h exp=%h", nm, op, m, s, r, dut_out(), exp);
    chk(nm, {18'd0, dut_out()}, {18'd0, exp});
    tick();
  endtask

  task automatic add(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s, input logic r,
                     input logic [13:0] exp);
    vec_t v;
    v.op = op; v.mm = m; v.stat = s; v.rdy = r; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic qpush(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s, input logic r,
                       input logic [13:0] exp);
    vec_t v;
    v.op = op; v.mm = m; v.stat = s; v.rdy = r; v.exp = exp;
    q.push_back(v);
  endtask

  // Expected cycle-by-cycle trace of one instruction, derived from the instruction's meaning.
  task automatic gen_instr(input logic [3:0] op, input int d, output bit stopped);
    logic [3:0] m, s;
    bit cond, taken, rel, memop;
    logic [3:0] alu;
    m = 4'($urandom); s = 4'($urandom);
    cond  = |(m & s);
    taken = ((op == 4 || op == 5) && cond) || ((op == 6 || op == 7) && !cond);
    rel   = (op == 5 || op == 7);
    memop = (op == 10 || op == 11);
    stopped = 0;
    qpush(op, 4'($urandom), 4'($urandom), 1'($urandom), mk(1,1,0,0,0,0,0,0,0,0,0));
    qpush(op, m, s, 1'($urandom), mk(0,taken,taken,taken && rel,0,0,0,0,0,0,0));
    if (op == 15) begin
      for (int k = 0; k < 3; k++)
        qpush(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,0,1,0));
      stopped = 1;
      return;
    end
    alu = (op == 1) ? 4'd1 : (op == 2 || memop) ? 4'd3 : 4'd0;
    qpush(op, 4'($urandom), 4'($urandom), 1'($urandom), mk(0,0,0,0,alu,0,0,0,0,0,0));
    if (memop) begin
      for (int k = 0; k <= ((d <= 15) ? d : 15); k++)
        qpush(op, 4'($urandom), 4'($urandom), (k == d), mk(0,0,0,0,3,0,0,1,(op == 11),0,0));
      if (d > 15) begin
        for (int k = 0; k < 3; k++)
          qpush(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,0,1,1));
        stopped = 1;
        return;
      end
    end else begin
      qpush(op, 4'($urandom), 4'($urandom), 1'($urandom),
            mk(0,0,0,0,(op == 2) ? 4'd2 : 4'd0,0,0,0,0,0,0));
    end
    qpush(op, 4'($urandom), 4'($urandom), 1'($urandom),
          mk(0,0,0,0,0,(op == 1 || op == 2 || op == 10),(op == 10),0,0,0,0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   stopped;
    logic [3:0] op;
    int   d;

    // START .. WRITEBACK of REG_OP, then branches, LOD with 3 MEM cycles, REG_IM, unlisted opcode.
    add(1,0,0,0, 0);
    add(1,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(1,4'hF,4'hF,1, 0);
    add(1,0,0,1, mk(0,0,0,0,1,0,0,0,0,0,0));
    add(1,0,0,1, 0);
    add(1,0,0,0, mk(0,0,0,0,0,1,0,0,0,0,0));
    add(6,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(6,2,2,0, 0);
    add(6,0,0,0, 0); add(6,0,0,0, 0); add(6,0,0,0, 0);
    add(6,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(6,2,4,0, mk(0,1,1,0,0,0,0,0,0,0,0));
    add(6,2,2,0, 0); add(6,2,2,0, 0); add(6,0,0,0, 0);
    add(5,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(5,8,9,0, mk(0,1,1,1,0,0,0,0,0,0,0));
    add(5,0,0,0, 0); add(5,0,0,0, 0); add(5,0,0,0, 0);
    add(4,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(4,1,2,0, 0);
    add(4,0,0,0, 0); add(4,0,0,0, 0); add(4,0,0,0, 0);
    add(7,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(7,0,4'hF,0, mk(0,1,1,1,0,0,0,0,0,0,0));
    add(7,0,0,0, 0); add(7,0,0,0, 0); add(7,0,0,0, 0);
    add(10,0,0,1, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(10,0,4'hF,1, 0);
    add(10,0,0,1, mk(0,0,0,0,3,0,0,0,0,0,0));
    add(10,0,0,0, mk(0,0,0,0,3,0,0,1,0,0,0));
    add(10,0,0,0, mk(0,0,0,0,3,0,0,1,0,0,0));
    add(10,0,0,1, mk(0,0,0,0,3,0,0,1,0,0,0));
    add(10,0,0,0, mk(0,0,0,0,0,1,1,0,0,0,0));
    add(2,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(2,0,0,0, 0);
    add(2,0,0,0, mk(0,0,0,0,3,0,0,0,0,0,0));
    add(2,0,0,0, mk(0,0,0,0,2,0,0,0,0,0,0));
    add(2,0,0,0, mk(0,0,0,0,0,1,0,0,0,0,0));
    add(3,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(3,4'hF,4'hF,1, 0);
    add(3,0,0,1, 0); add(3,0,0,0, 0); add(3,0,0,1, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.op, v.mm, v.stat, v.rdy, v.exp, $sformatf("vec[%0d]", i));
    end

    // STR with no ready: 16 MEM cycles then HALT with err.
    step(11,0,0,1, mk(1,1,0,0,0,0,0,0,0,0,0), "str_fetch");
    step(11,3,3,1, 0, "str_decode");
    step(11,0,0,1, mk(0,0,0,0,3,0,0,0,0,0,0), "str_exec");
    for (int k = 0; k < 16; k++)
      step(11,0,0,0, mk(0,0,0,0,3,0,0,1,1,0,0), $sformatf("str_mem[%0d]", k));
    step(11,0,0,1, mk(0,0,0,0,0,0,0,0,0,1,1), "str_timeout");
    step(1,0,0,1, mk(0,0,0,0,0,0,0,0,0,1,1), "str_halt_hold");
    rst = 1'b1; tick(); rst = 1'b0;
    step(1,0,0,0, 0, "str_rst_start");
    step(1,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0), "str_rst_fetch");

    // HLT at DECODE, then 10 quiet HALT cycles, then reset mid-HALT.
    step(15,4'hF,4'hF,1, 0, "hlt_decode");
    for (int k = 0; k < 10; k++)
      step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
           mk(0,0,0,0,0,0,0,0,0,1,0), $sformatf("hlt_hold[%0d]", k));
    rst = 1'b1; tick(); rst = 1'b0;
    step(1,0,0,0, 0, "hlt_rst_start");
    step(1,0,0,0, mk(1,1,0,0,0,0,0,0,0,0,0), "hlt_rst_fetch");

    // Random instruction streams checked against the instruction-level model.
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete();
    qpush(0, 0, 0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 19) == 0) ? 4'd15 : ops[$urandom_range(0, 13)];
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 4));
      gen_instr(op, d, stopped);
      while (q.size() > 0) begin
        v = q.pop_front();
        step(v.op, v.mm, v.stat, v.rdy, v.exp, $sformatf("rnd[%0d] op=%0d d=%0d", n, op, d));
      end
      if (stopped) begin
        rst = 1'b1; tick(); rst = 1'b0;
        qpush(0, 0, 0, 0, 0);
      end
    end
    while (q.size() > 0) begin
      v = q.pop_front();
      step(v.op, v.mm, v.stat, v.rdy, v.exp, "rnd_tail");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
